// File: rtl/i2c_reg_slave.sv
// I2C target with a pointer-addressed bank of read-only and read/write byte registers.
// Both bus lines are oversampled on clk; the target drives SDA only as an open-drain pull-down.
module i2c_reg_slave #(
  parameter logic [6:0] I2C_ADDR    = 7'h64,
  parameter int         NUM_RO      = 4,
  parameter int         NUM_RW      = 4,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scl_in,
  input  logic                  sda_in,
  output logic                  sda_oe,
  input  logic [8*NUM_RO-1:0]   ro_data,
  output logic [8*NUM_RW-1:0]   rw_data,
  output logic [NUM_RW-1:0]     wr_strobe,
  output logic [2:0]            i2c_state,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_ACK   = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4,
    S_MACK  = 3'd5,
    S_WAIT  = 3'd6
  } state_t;

  localparam logic [7:0] LP_LAST = 8'(NUM_RO + NUM_RW - 1);

  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_d, r_sda_d;
  logic                   w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  state_t                 r_state;
  logic [7:0]             r_shift, r_ptr, w_ptr_inc, w_rdata;
  logic [3:0]             r_cnt;
  logic                   r_sda_oe, r_busy, r_rd, r_first, r_wr_pend;
  logic [NUM_RW-1:0]      r_wr_strobe;
  logic [NUM_RW-1:0][7:0] r_rw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_in};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  // SCL held high across both samples: any SDA edge is a bus condition, not data
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

  assign w_ptr_inc  = (r_ptr >= LP_LAST) ? 8'd0 : r_ptr + 8'd1;

  always_comb begin
    w_rdata = 8'h00;
    for (int i = 0; i < NUM_RO; i++)
      if (r_ptr == 8'(i)) w_rdata = ro_data[i*8 +: 8];
    for (int j = 0; j < NUM_RW; j++)
      if (r_ptr == 8'(NUM_RO + j)) w_rdata = r_rw[j];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_shift     <= 8'h00;
      r_ptr       <= 8'h00;
      r_cnt       <= 4'd0;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_rd        <= 1'b0;
      r_first     <= 1'b0;
      r_wr_pend   <= 1'b0;
      r_wr_strobe <= '0;
      r_rw        <= '0;
    end else begin
      r_wr_strobe <= '0;
      r_wr_pend   <= 1'b0;
      // Received byte is committed one cycle after its last bit is shifted in
      if (r_wr_pend) begin
        if (r_first) begin
          r_ptr   <= r_shift;
          r_first <= 1'b0;
        end else begin
          for (int j = 0; j < NUM_RW; j++)
            if (r_ptr == 8'(NUM_RO + j)) begin
              r_rw[j]        <= r_shift;
              r_wr_strobe[j] <= 1'b1;
            end
          r_ptr <= w_ptr_inc;
        end
      end
      if (w_stop) begin
        r_state  <= S_IDLE;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else if (w_start) begin
        r_state  <= S_ADDR;
        r_cnt    <= 4'd0;
        r_sda_oe <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR: begin
            if (w_scl_rise) begin
              r_shift <= {r_shift[6:0], w_sda};
              r_cnt   <= r_cnt + 4'd1;
            end else if (w_scl_fall && r_cnt == 4'd8) begin
              if (r_shift[7:1] == I2C_ADDR) begin
                r_state  <= S_ACK;
                r_sda_oe <= 1'b1;
                r_busy   <= 1'b1;
                r_rd     <= r_shift[0];
                r_first  <= 1'b1;
              end else begin
                r_state  <= S_WAIT;
                r_sda_oe <= 1'b0;
                r_busy   <= 1'b0;
              end
            end
          end
          S_ACK: begin
            if (w_scl_fall) begin
              r_cnt <= 4'd0;
              if (r_rd) begin
                r_state  <= S_READ;
                r_shift  <= w_rdata;
                r_sda_oe <= ~w_rdata[7];
              end else begin
                r_state  <= S_WRITE;
                r_sda_oe <= 1'b0;
              end
            end
          end
          S_WRITE: begin
            if (w_scl_rise && r_cnt < 4'd8) begin
              r_shift   <= {r_shift[6:0], w_sda};
              r_cnt     <= r_cnt + 4'd1;
              r_wr_pend <= (r_cnt == 4'd7);
            end else if (w_scl_fall && r_cnt == 4'd8) begin
              r_state  <= S_ACK;
              r_sda_oe <= 1'b1;
            end
          end
          S_READ: begin
            if (w_scl_rise) begin
              r_cnt <= r_cnt + 4'd1;
            end else if (w_scl_fall) begin
              if (r_cnt == 4'd8) begin
                r_state  <= S_MACK;
                r_sda_oe <= 1'b0;
                r_ptr    <= w_ptr_inc;
              end else begin
                r_shift  <= {r_shift[6:0], 1'b0};
                r_sda_oe <= ~r_shift[6];
              end
            end
          end
          S_MACK: begin
            // shift[0] holds the master's ACK/NACK bit until the slot ends
            if (w_scl_rise) begin
              r_shift[0] <= w_sda;
            end else if (w_scl_fall) begin
              r_cnt <= 4'd0;
              if (r_shift[0]) begin
                r_state  <= S_WAIT;
                r_sda_oe <= 1'b0;
              end else begin
                r_state  <= S_READ;
                r_shift  <= w_rdata;
                r_sda_oe <= ~w_rdata[7];
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe    = r_sda_oe;
  assign busy      = r_busy;
  assign wr_strobe = r_wr_strobe;
  assign rw_data   = r_rw;
  assign i2c_state = r_state;

endmodule
